// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//
// Shared definitions for the input-conditioning blocks.
//
// Contents:
//   deb_state_t  2-bit state encoding of the debounce FSM
//                LOW     : output low, input agrees
//                WAIT_HI : input seen high, counting stable cycles
//                HIGH    : output high, input agrees
//                WAIT_LO : input seen low, counting stable cycles
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        WAIT_HI = 2'd1,
        HIGH    = 2'd2,
        WAIT_LO = 2'd3
    } deb_state_t;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Two-flop synchroniser for a single asynchronous bit. The first flop may go
// metastable. The second gives it a full cycle to resolve before anything
// downstream looks at the value.
//
// Ports:
//   clk    in  1  destination-domain rising-edge clock
//   reset  in  1  asynchronous active-low reset, clears both flops
//   d      in  1  asynchronous input
//   q      out 1  synchronised copy of d, two clk edges later
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage shift. Only q is safe to use in the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_edge.sv
// -----------------------------------------------------------------------------
// debounce_edge
//
// Conditions a raw asynchronous input (button or external strobe). The input
// is synchronised into clk, and the new level must hold for STABLE
// consecutive synchronised cycles before the registered output level changes.
// Each accepted change also produces a single-cycle rise or fall pulse,
// registered and coincident with the change of dout.
//
// Parameters:
//   STABLE  consecutive synchronised cycles a new level must hold (1..65535)
//   CNT_W   counter width, derived from STABLE
//
// Ports:
//   clk    in  1  rising-edge clock, the only clock
//   reset  in  1  asynchronous active-low reset, clears all state
//   din    in  1  raw asynchronous input, may glitch
//   dout   out 1  debounced level, registered
//   rise   out 1  one-cycle pulse in the cycle dout goes 0->1
//   fall   out 1  one-cycle pulse in the cycle dout goes 1->0
// -----------------------------------------------------------------------------
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int STABLE = 4,
    parameter int CNT_W  = $clog2(STABLE + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    // The count that completes a transition. The cycle that moves the FSM into
    // a WAIT state is counted as the first stable cycle. Reaching LAST on a
    // further agreeing cycle means STABLE cycles in total.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             s2;
    deb_state_t       state,     state_nxt;
    logic [CNT_W-1:0] cnt,       cnt_nxt;
    logic             dout_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    // Only the synchronised copy of din is allowed to steer the FSM.
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (din),
        .q     (s2)
    );

    // Next-state logic.
    // Pulses default to 0, so each pulse lasts exactly one cycle. A WAIT state
    // that sees the old level again goes back to its stable state with no
    // pulse, which is how glitches are rejected. The counter is only advanced
    // while below LAST, so it can never wrap.
    // With STABLE == 1 the first synchronised cycle is already enough, so the
    // stable states jump straight across and skip the WAIT states.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;

        case (state)
            LOW: begin
                if (s2) begin
                    if (STABLE == 1) begin
                        state_nxt = HIGH;
                        dout_nxt  = 1'b1;
                        rise_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = WAIT_HI;
                        cnt_nxt   = ONE;
                    end
                end
            end

            WAIT_HI: begin
                if (!s2) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = HIGH;
                    dout_nxt  = 1'b1;
                    rise_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + ONE;
                end
            end

            HIGH: begin
                if (!s2) begin
                    if (STABLE == 1) begin
                        state_nxt = LOW;
                        dout_nxt  = 1'b0;
                        fall_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = WAIT_LO;
                        cnt_nxt   = ONE;
                    end
                end
            end

            WAIT_LO: begin
                if (s2) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = LOW;
                    dout_nxt  = 1'b0;
                    fall_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + ONE;
                end
            end

            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
                dout_nxt  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    // The reset is asynchronous, so asserting it mid-count drops dout and any
    // pulse in flight straight away. No fall is produced for a dout that was
    // high when reset arrived.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dout  <= dout_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

endmodule

// File: tb/tb_debounce_edge.sv
// -----------------------------------------------------------------------------
// tb_debounce_edge
//
// Drives two instances of debounce_edge, one with STABLE=4 and one with
// STABLE=1, from a shared 10 ns clock and reset. The stimulus process drives
// din and queues the pulses and dout levels it expects, each tagged with the
// clock cycle. A separate monitor process samples 1 ns after every falling
// clock edge (and after reset asserts). It pops and compares those
// expectations and reports any pulse nobody asked for.
// -----------------------------------------------------------------------------
module tb_debounce_edge;

    typedef struct {
        int   cycle;
        logic is_rise;
    } pulse_t;

    typedef struct {
        int   cycle;
        logic which;
        logic val;
    } level_t;

    logic clk = 1'b0;
    logic reset;
    logic din4, din1;
    logic dout4, rise4, fall4;
    logic dout1, rise1, fall1;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    pulse_t pq4[$];
    pulse_t pq1[$];
    level_t lq[$];

    debounce_edge #(.STABLE(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .din   (din4),
        .dout  (dout4),
        .rise  (rise4),
        .fall  (fall4)
    );

    debounce_edge #(.STABLE(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .din   (din1),
        .dout  (dout1),
        .rise  (rise1),
        .fall  (fall1)
    );

    // 10 ns clock, and a count of rising edges used to timestamp expectations.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare one value and report it if it is wrong.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Match this cycle's pulses for one instance against its pulse queue.
    task automatic scorePulse(input bit which, input logic r, input logic f);
        pulse_t e;
        bit     have;
        string  tag;
        tag  = which ? "s1" : "s4";
        have = which ? (pq1.size() > 0) : (pq4.size() > 0);
        if (r || f) begin
            if (!have) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse_%s: got rise=%0b fall=%0b, expected none (cycle %0d)",
                         tag, r, f, cyc);
            end else begin
                if (which) e = pq1.pop_front();
                else       e = pq4.pop_front();
                checkOutput({"pulse_is_rise_", tag}, int'(r), int'(e.is_rise));
                checkOutput({"pulse_cycle_", tag}, cyc, e.cycle);
            end
        end else if (have) begin
            if (which) e = pq1[0];
            else       e = pq4[0];
            if (e.cycle < cyc) begin
                if (which) void'(pq1.pop_front());
                else       void'(pq4.pop_front());
                checks++;
                errors++;
                $display("[TB] FAIL missing_pulse_%s: got no pulse, expected %s at cycle %0d (now %0d)",
                         tag, e.is_rise ? "rise" : "fall", e.cycle, cyc);
            end
        end
        checkOutput({"rise_fall_exclusive_", tag}, int'(r && f), 0);
    endtask

    // Monitor process: does all the comparing.
    initial begin
        level_t l;
        forever begin
            @(negedge clk or negedge reset);
            #1;
            if (done) begin
                checkOutput("pending_pulses_s4", pq4.size(), 0);
                checkOutput("pending_pulses_s1", pq1.size(), 0);
                checkOutput("pending_levels", lq.size(), 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
            if (!reset) begin
                checkOutput("reset_clear", int'({dout4, rise4, fall4, dout1, rise1, fall1}), 0);
            end else begin
                scorePulse(1'b0, rise4, fall4);
                scorePulse(1'b1, rise1, fall1);
                while (lq.size() > 0 && lq[0].cycle <= cyc) begin
                    l = lq.pop_front();
                    checkOutput(l.which ? "dout_s1" : "dout_s4",
                                int'(l.which ? dout1 : dout4), int'(l.val));
                end
            end
        end
    end

    // Stimulus helpers. Inputs change on the falling edge.
    task automatic applyStimulus(input bit which, input logic val);
        @(negedge clk);
        if (which) din1 = val;
        else       din4 = val;
    endtask

    task automatic expectPulse(input bit which, input logic is_rise, input int delta);
        pulse_t e;
        e.cycle   = cyc + delta;
        e.is_rise = is_rise;
        if (which) pq1.push_back(e);
        else       pq4.push_back(e);
    endtask

    task automatic expectLevel(input bit which, input logic val, input int delta);
        level_t l;
        l.cycle = cyc + delta;
        l.which = which;
        l.val   = val;
        lq.push_back(l);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Directed scenarios. A din change driven at falling edge c is captured at
    // edge c+1. It reaches dout at edge c+1+STABLE+1: c+6 for STABLE=4, c+3
    // for STABLE=1.
    initial begin
        reset = 1'b0;
        din4  = 1'b1;
        din1  = 1'b0;

        // Hold reset 20 ns with din high, then release.
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        expectPulse(1'b0, 1'b1, 6);
        expectLevel(1'b0, 1'b0, 5);
        expectLevel(1'b0, 1'b1, 6);
        expectLevel(1'b0, 1'b1, 7);
        waitCycles(10);

        // Clean fall.
        applyStimulus(1'b0, 1'b0);
        expectPulse(1'b0, 1'b0, 6);
        expectLevel(1'b0, 1'b1, 5);
        expectLevel(1'b0, 1'b0, 6);
        waitCycles(8);

        // High glitch of 3 cycles while low.
        applyStimulus(1'b0, 1'b1);
        waitCycles(2);
        applyStimulus(1'b0, 1'b0);
        expectLevel(1'b0, 1'b0, 8);
        waitCycles(10);

        // Clean rise.
        applyStimulus(1'b0, 1'b1);
        expectPulse(1'b0, 1'b1, 6);
        expectLevel(1'b0, 1'b0, 5);
        expectLevel(1'b0, 1'b1, 6);
        waitCycles(8);

        // Low glitch of 3 cycles while high.
        applyStimulus(1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(1'b0, 1'b1);
        expectLevel(1'b0, 1'b1, 8);
        waitCycles(10);

        // Low pulse of exactly 4 cycles: accepted, then the return is accepted.
        applyStimulus(1'b0, 1'b0);
        expectPulse(1'b0, 1'b0, 6);
        expectLevel(1'b0, 1'b1, 5);
        expectLevel(1'b0, 1'b0, 6);
        waitCycles(3);
        applyStimulus(1'b0, 1'b1);
        expectPulse(1'b0, 1'b1, 6);
        expectLevel(1'b0, 1'b0, 5);
        expectLevel(1'b0, 1'b1, 6);
        waitCycles(8);

        // Back to low for the mid-count reset.
        applyStimulus(1'b0, 1'b0);
        expectPulse(1'b0, 1'b0, 6);
        expectLevel(1'b0, 1'b0, 6);
        waitCycles(8);

        // Rise in progress, reset when the count is 2, release with din high.
        applyStimulus(1'b0, 1'b1);
        waitCycles(4);
        reset = 1'b0;
        waitCycles(2);
        reset = 1'b1;
        expectPulse(1'b0, 1'b1, 6);
        expectLevel(1'b0, 1'b0, 5);
        expectLevel(1'b0, 1'b1, 6);
        waitCycles(8);

        // Asynchronous reset mid-cycle while dout is high: no fall afterwards.
        @(negedge clk);
        #2;
        reset = 1'b0;
        din4  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        expectLevel(1'b0, 1'b0, 3);
        waitCycles(8);

        // STABLE=1: rise, then a 1-cycle low glitch gives fall then rise.
        applyStimulus(1'b1, 1'b1);
        expectPulse(1'b1, 1'b1, 3);
        expectLevel(1'b1, 1'b0, 2);
        expectLevel(1'b1, 1'b1, 3);
        waitCycles(4);
        applyStimulus(1'b1, 1'b0);
        expectPulse(1'b1, 1'b0, 3);
        expectLevel(1'b1, 1'b1, 2);
        expectLevel(1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b1);
        expectPulse(1'b1, 1'b1, 3);
        expectLevel(1'b1, 1'b1, 3);
        waitCycles(6);

        done = 1'b1;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test, expected end before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
